// File: rtl/dm_lsu_pkg.sv
// Shared definitions for the load/store data memory: funct3 encodings,
// FSM states and the access-legality check.
package dm_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RESP} dm_state_e;

  // Flags misaligned halfword/word accesses, illegal funct3 and unsigned stores.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] a,
                                         input logic       we);
    logic bad;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_BU:   bad = we;
      F3_H:    bad = a[0];
      F3_HU:   bad = we | a[0];
      F3_W:    bad = (a != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dm_byte_ram.sv
// Word-organised RAM with per-byte write enables; combinational read so the
// owning block controls where the read is registered.
module dm_byte_ram #(
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic [3:0]               we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we[i]) r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = r_mem[addr];

endmodule

// File: rtl/datamemory_lsu.sv
// RV32 load/store data memory: valid/ready request, held response channel,
// lane alignment and sign/zero extension, error reporting, RD_LATENCY delay.
module datamemory_lsu
  import dm_lsu_pkg::*;
#(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err
);

  localparam int unsigned DEPTH = 2 ** (DM_ADDRESS - 2);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("datamemory_lsu: DATA_W must be 32");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("datamemory_lsu: RD_LATENCY must be 1..4");
  end

  dm_state_e             r_state;
  logic [1:0]            r_cnt;
  logic [DM_ADDRESS-1:0] r_addr;
  logic [2:0]            r_funct3;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_err;
  logic [DM_ADDRESS-1:0] w_rd_addr;
  logic [2:0]            w_rd_f3;
  logic [3:0]            w_be;
  logic [DATA_W-1:0]     w_wdata;
  logic [DATA_W-1:0]     w_rword;
  logic [DATA_W-1:0]     w_load;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  assign w_accept  = req_valid && req_ready;
  assign w_err     = is_misaligned(req_funct3, req_addr[1:0], req_we);
  // Idle reads the live request (latency 1); later reads use the captured one.
  assign w_rd_addr = (r_state == S_IDLE) ? req_addr   : r_addr;
  assign w_rd_f3   = (r_state == S_IDLE) ? req_funct3 : r_funct3;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = req_wdata;
    case (req_funct3)
      F3_B: begin
        w_be    = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      F3_H: begin
        w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!(w_accept && req_we && !w_err)) w_be = '0;
  end

  dm_byte_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (w_be),
    .addr  (w_rd_addr[DM_ADDRESS-1:2]),
    .wdata (w_wdata),
    .rdata (w_rword)
  );

  always_comb begin
    w_byte = w_rword[8*w_rd_addr[1:0] +: 8];
    w_half = w_rd_addr[1] ? w_rword[31:16] : w_rword[15:0];
    case (w_rd_f3)
      F3_B:    w_load = {{24{w_byte[7]}}, w_byte};
      F3_BU:   w_load = {24'h0, w_byte};
      F3_H:    w_load = {{16{w_half[15]}}, w_half};
      F3_HU:   w_load = {16'h0, w_half};
      default: w_load = w_rword;
    endcase
  end

  // S_LOAD lasts RD_LATENCY-1 cycles so the response shows RD_LATENCY edges
  // after acceptance; latency 1 registers the load straight from idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_funct3 <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr   <= req_addr;
            r_funct3 <= req_funct3;
            r_rdata  <= '0;
            r_err    <= w_err;
            if (w_err || req_we) begin
              r_state <= S_RESP;
            end else if (RD_LATENCY == 1) begin
              r_rdata <= w_load;
              r_state <= S_RESP;
            end else begin
              r_cnt   <= 2'(RD_LATENCY - 1);
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          r_cnt <= r_cnt - 2'd1;
          if (r_cnt == 2'd1) begin
            r_rdata <= w_load;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state <= S_IDLE;
            r_rdata <= '0;
            r_err   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datamemory_lsu.sv
// Directed bench for datamemory_lsu: one latency-1 instance and one latency-3
// instance sharing request inputs; sel picks which outputs are observed.
module tb_datamemory_lsu;

  logic        clk = 1'b0;
  logic        rst_n, rst3_n;
  logic        rv1, rv3;
  logic        req_we;
  logic [8:0]  req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        resp_ready;
  logic        rr1, rr3, rsv1, rsv3, er1, er3;
  logic [31:0] rd1, rd3;
  logic        sel;
  logic        m_req_ready, m_resp_valid, m_resp_err;
  logic [31:0] m_resp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  datamemory_lsu #(.DM_ADDRESS(9), .DATA_W(32), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(rr1), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .resp_valid(rsv1), .resp_ready(resp_ready), .resp_rdata(rd1), .resp_err(er1)
  );

  datamemory_lsu #(.DM_ADDRESS(9), .DATA_W(32), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .req_valid(rv3), .req_ready(rr3), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .resp_valid(rsv3), .resp_ready(resp_ready), .resp_rdata(rd3), .resp_err(er3)
  );

  assign m_req_ready  = sel ? rr3  : rr1;
  assign m_resp_valid = sel ? rsv3 : rsv1;
  assign m_resp_rdata = sel ? rd3  : rd1;
  assign m_resp_err   = sel ? er3  : er1;

  // Issues one request, waits (bounded) for its response, then accepts it.
  task automatic do_req(input logic s, input logic we, input logic [8:0] addr,
                        input logic [2:0] f3, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    sel = s;
    @(negedge clk);
    req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wd;
    if (s) rv3 = 1'b1; else rv1 = 1'b1;
    @(posedge clk); #1;
    rv1 = 1'b0; rv3 = 1'b0;
    lat = 1;
    while (!m_resp_valid && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
    n_tests++;
    if (!m_resp_valid) begin
      n_fail++;
      $display("FAIL resp_timeout: resp_valid=%0b after %0d cycles, required 1", m_resp_valid, lat);
    end
    rd = m_resp_rdata;
    er = m_resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst3_n = 1'b0;
    rv1 = 1'b0; rv3 = 1'b0; resp_ready = 1'b0; sel = 1'b0;
    req_we = 1'b0; req_addr = '0; req_funct3 = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({rsv1, rd1, er1} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid/rdata/err=%0b/%h/%0b, required 0/00000000/0", rsv1, rd1, er1);
    end
    n_tests++;
    if (rsv3 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid3: got %0b, required 0", rsv3);
    end
    @(negedge clk);
    rst_n = 1'b1; rst3_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({rr1, rr3} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, required 11", {rr1, rr3});
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, 1'b1, 9'h010, 3'b010, 32'hDEADBEEF, rd, er, lat);
    n_tests++;
    if ({lat, er, rd} !== {32'd1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL sw_resp: lat/err/rdata=%0d/%0b/%h, required 1/0/00000000", lat, er, rd);
    end
    do_req(1'b0, 1'b0, 9'h010, 3'b010, 32'h0, rd, er, lat);
    n_tests++;
    if ({lat, er, rd} !== {32'd1, 1'b0, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL lw_resp: lat/err/rdata=%0d/%0b/%h, required 1/0/deadbeef", lat, er, rd);
    end
  endtask

  task automatic test_subword_loads();
    logic [31:0] rd; logic er; int lat;
    logic [8:0]  addrs [4] = '{9'h011, 9'h013, 9'h012, 9'h010};
    logic [2:0]  f3s   [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] exps  [4] = '{32'hFFFFFFBE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 1'b0, addrs[i], f3s[i], 32'h0, rd, er, lat);
      n_tests++;
      if ({er, rd} !== {1'b0, exps[i]}) begin
        n_fail++;
        $display("FAIL subword_load[%0d]: err/rdata=%0b/%h, required 0/%h", i, er, rd, exps[i]);
      end
    end
  endtask

  task automatic test_byte_store();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, 1'b1, 9'h012, 3'b000, 32'h1234565A, rd, er, lat);
    do_req(1'b0, 1'b0, 9'h010, 3'b010, 32'h0, rd, er, lat);
    n_tests++;
    if (rd !== 32'hDE5ABEEF) begin
      n_fail++;
      $display("FAIL sb_merge: got %h, required de5abeef", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    logic        wes   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [8:0]  addrs [4] = '{9'h011, 9'h012, 9'h010, 9'h010};
    logic [2:0]  f3s   [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, wes[i], addrs[i], f3s[i], 32'h11223344, rd, er, lat);
      n_tests++;
      if ({lat, er, rd} !== {32'd1, 1'b1, 32'h0}) begin
        n_fail++;
        $display("FAIL err_case[%0d]: lat/err/rdata=%0d/%0b/%h, required 1/1/00000000", i, lat, er, rd);
      end
    end
    do_req(1'b0, 1'b0, 9'h010, 3'b010, 32'h0, rd, er, lat);
    n_tests++;
    if (rd !== 32'hDE5ABEEF) begin
      n_fail++;
      $display("FAIL err_no_write: got %h, required de5abeef", rd);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat;
    int bad = 0;
    sel = 1'b0;
    @(negedge clk);
    req_we = 1'b0; req_addr = 9'h010; req_funct3 = 3'b010; rv1 = 1'b1;
    @(posedge clk); #1;
    rv1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!(rsv1 === 1'b1 && rd1 === 32'hDE5ABEEF && rr1 === 1'b0)) bad++;
      if (i == 2) begin
        req_we = 1'b1; req_wdata = 32'h0; rv1 = 1'b1;
      end
      @(posedge clk); #1;
      rv1 = 1'b0;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stall_stable: %0d unstable cycles, required 0", bad);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    n_tests++;
    if ({rsv1, rr1} !== 2'b01) begin
      n_fail++;
      $display("FAIL stall_release: valid/ready=%b, required 01", {rsv1, rr1});
    end
    do_req(1'b0, 1'b0, 9'h010, 3'b010, 32'h0, rd, er, lat);
    n_tests++;
    if (rd !== 32'hDE5ABEEF) begin
      n_fail++;
      $display("FAIL stall_ignored_req: got %h, required de5abeef", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat;
    int bad = 0;
    sel = 1'b0;
    @(negedge clk);
    req_we = 1'b1; req_addr = 9'h020; req_funct3 = 3'b010; req_wdata = 32'h0BADF00D;
    rv1 = 1'b1; resp_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (rsv1 !== ((k % 2) == 1)) bad++;
    end
    rv1 = 1'b0; resp_ready = 1'b0;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL b2b_throughput: %0d wrong cycles, required 0", bad);
    end
    @(posedge clk); #1;
    do_req(1'b0, 1'b0, 9'h022, 3'b001, 32'h0, rd, er, lat);
    n_tests++;
    if (rd !== 32'h00000BAD) begin
      n_fail++;
      $display("FAIL b2b_lh: got %h, required 00000bad", rd);
    end
    do_req(1'b0, 1'b0, 9'h021, 3'b000, 32'h0, rd, er, lat);
    n_tests++;
    if (rd !== 32'hFFFFFFF0) begin
      n_fail++;
      $display("FAIL b2b_lb: got %h, required fffffff0", rd);
    end
  endtask

  task automatic test_latency3();
    logic [31:0] rd; logic er; int lat;
    int seen = 0;
    do_req(1'b1, 1'b1, 9'h040, 3'b010, 32'h01234567, rd, er, lat);
    n_tests++;
    if ({lat, er} !== {32'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL l3_store: lat/err=%0d/%0b, required 1/0", lat, er);
    end
    do_req(1'b1, 1'b0, 9'h040, 3'b010, 32'h0, rd, er, lat);
    n_tests++;
    if ({lat, rd} !== {32'd3, 32'h01234567}) begin
      n_fail++;
      $display("FAIL l3_load: lat/rdata=%0d/%h, required 3/01234567", lat, rd);
    end
    // Reset while a response is being held.
    @(negedge clk);
    req_we = 1'b0; req_addr = 9'h040; req_funct3 = 3'b010; rv3 = 1'b1;
    @(posedge clk); #1;
    rv3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (rsv3 !== 1'b1) begin
      n_fail++;
      $display("FAIL l3_held: resp_valid=%0b, required 1", rsv3);
    end
    rst3_n = 1'b0;
    #1;
    n_tests++;
    if (rsv3 !== 1'b0) begin
      n_fail++;
      $display("FAIL l3_async_reset: resp_valid=%0b, required 0", rsv3);
    end
    @(negedge clk);
    rst3_n = 1'b1;
    // Reset in the middle of a load.
    @(negedge clk);
    rv3 = 1'b1;
    @(posedge clk); #1;
    rv3 = 1'b0;
    @(posedge clk); #1;
    rst3_n = 1'b0;
    @(negedge clk);
    rst3_n = 1'b1;
    #1;
    n_tests++;
    if (rr3 !== 1'b1) begin
      n_fail++;
      $display("FAIL l3_ready_after_reset: got %0b, required 1", rr3);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rsv3 !== 1'b0) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL l3_stale_resp: %0d stale cycles, required 0", seen);
    end
    do_req(1'b1, 1'b0, 9'h042, 3'b101, 32'h0, rd, er, lat);
    n_tests++;
    if ({lat, rd} !== {32'd3, 32'h00000123}) begin
      n_fail++;
      $display("FAIL l3_ram_kept: lat/rdata=%0d/%h, required 3/00000123", lat, rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_load();
    test_subword_loads();
    test_byte_store();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_latency3();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
